// File: rtl/io_mux_pkg.sv
// Shared types and constants for the user-pad ownership controller.
package io_mux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_SWITCH = 2'd2,
    ST_ENABLE = 2'd3
  } state_e;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned SEL_W   = 2;
  localparam int unsigned GUARD_W = 8;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned OFF_W   = 8;

  localparam logic [OFF_W-1:0] OFF_CTRL   = 8'h00;
  localparam logic [OFF_W-1:0] OFF_STATUS = 8'h04;
  localparam logic [OFF_W-1:0] OFF_GUARD  = 8'h08;

  localparam int unsigned ST_SEL_LSB  = 0;
  localparam int unsigned ST_BUSY_BIT = 8;
  localparam int unsigned ST_ERR_BIT  = 9;
  localparam int unsigned ST_CNT_LSB  = 16;

  // Assemble the STATUS read word from its fields.
  function automatic logic [DATA_W-1:0] pack_status(input logic [SEL_W-1:0] sel,
                                                   input logic             busy,
                                                   input logic             err,
                                                   input logic [CNT_W-1:0] cnt);
    logic [DATA_W-1:0] w;
    w = '0;
    w[ST_SEL_LSB +: SEL_W] = sel;
    w[ST_BUSY_BIT]         = busy;
    w[ST_ERR_BIT]          = err;
    w[ST_CNT_LSB +: CNT_W] = cnt;
    return w;
  endfunction

endpackage

// File: rtl/io_mux_wb_regs.sv
// Wishbone slave for the pad controller: decode, single-cycle ack,
// GUARD register and sticky err with clear-on-STATUS-read.
module io_mux_wb_regs
  import io_mux_pkg::*;
#(
  parameter int unsigned GUARD_RST = 8,
  parameter logic [31:0] ADDR_BASE = 32'h3000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  input  logic [1:0]        sel_i,
  input  logic              busy_i,
  input  logic [15:0]       count_i,
  input  logic [1:0]        target_i,
  input  logic              err_set_i,
  output logic              ctrl_wr_c,
  output logic [1:0]        ctrl_dat_c,
  output logic [7:0]        guard_o
);

  logic                 acc_c;
  logic                 hit_c;
  logic                 wr_c;
  logic                 rd_c;
  logic [OFF_W-1:0]     off_c;
  logic [DATA_W-1:0]    rdata_c;

  logic                 ack_q, ack_d;
  logic [DATA_W-1:0]    dat_q, dat_d;
  logic [GUARD_W-1:0]   guard_q, guard_d;
  logic                 err_q, err_d;

  // Only the low byte carries register fields.
  logic unused_bits;
  assign unused_bits = ^{wbs_dat_i[31:8], wbs_sel_i[3:1]};

  // Holding ack low between accesses enforces the every-other-cycle rate.
  always_comb begin
    acc_c = wbs_cyc_i & wbs_stb_i & ~ack_q;
    hit_c = (wbs_adr_i[31:8] == ADDR_BASE[31:8]);
    off_c = wbs_adr_i[OFF_W-1:0];
    wr_c  = acc_c & hit_c & wbs_we_i;
    rd_c  = acc_c & hit_c & ~wbs_we_i;
  end

  assign ctrl_wr_c  = wr_c & wbs_sel_i[0] & (off_c == OFF_CTRL);
  assign ctrl_dat_c = wbs_dat_i[SEL_W-1:0];

  always_comb begin
    rdata_c = '0;
    if (hit_c) begin
      case (off_c)
        OFF_CTRL:   rdata_c = {{(DATA_W-SEL_W){1'b0}}, target_i};
        OFF_STATUS: rdata_c = pack_status(sel_i, busy_i, err_q, count_i);
        OFF_GUARD:  rdata_c = {{(DATA_W-GUARD_W){1'b0}}, guard_q};
        default:    rdata_c = '0;
      endcase
    end
  end

  always_comb begin
    ack_d   = acc_c;
    dat_d   = (acc_c & ~wbs_we_i) ? rdata_c : '0;
    guard_d = guard_q;
    err_d   = err_q;
    if (wr_c && wbs_sel_i[0] && (off_c == OFF_GUARD)) begin
      guard_d = (wbs_dat_i[GUARD_W-1:0] == '0) ? GUARD_W'(1) : wbs_dat_i[GUARD_W-1:0];
    end
    if (rd_c && (off_c == OFF_STATUS)) begin
      err_d = 1'b0;
    end
    if (err_set_i) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q   <= 1'b0;
      dat_q   <= '0;
      guard_q <= GUARD_W'(GUARD_RST);
      err_q   <= 1'b0;
    end else begin
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      guard_q <= guard_d;
      err_q   <= err_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign guard_o   = guard_q;

endmodule

// File: rtl/io_mux_ctrl.sv
// Break-before-make owner handover for the shared user pads: hold all pads
// as inputs for GUARD cycles, switch the mux, then release the new owner.
module io_mux_ctrl
  import io_mux_pkg::*;
#(
  parameter int unsigned NPROJ     = 4,
  parameter int unsigned GUARD_RST = 8,
  parameter logic [31:0] ADDR_BASE = 32'h3000_0000
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             wbs_cyc_i,
  input  logic             wbs_stb_i,
  input  logic             wbs_we_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic [31:0]      wbs_adr_i,
  input  logic [31:0]      wbs_dat_i,
  output logic             wbs_ack_o,
  output logic [31:0]      wbs_dat_o,
  output logic [1:0]       sel_o,
  output logic [NPROJ-1:0] en_o,
  output logic             io_hold_o,
  output logic             busy_o,
  output logic             irq_o
);

  localparam int unsigned       LIM_W     = SEL_W + 1;
  localparam logic [LIM_W-1:0]  NPROJ_LIM = LIM_W'(NPROJ);
  localparam logic [NPROJ-1:0]  EN_RST    = NPROJ'(1);

  state_e               state_q, state_d;
  logic [GUARD_W-1:0]   cnt_q, cnt_d;
  logic [SEL_W-1:0]     target_q, target_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic [NPROJ-1:0]     en_q, en_d;
  logic                 hold_q, hold_d;
  logic                 busy_q, busy_d;
  logic                 irq_q, irq_d;
  logic [CNT_W-1:0]     count_q, count_d;

  logic                 ctrl_wr_c;
  logic [SEL_W-1:0]     ctrl_dat_c;
  logic [GUARD_W-1:0]   guard_c;
  logic                 tgt_ok_c;
  logic                 accept_c;
  logic                 start_c;
  logic                 err_set_c;

  io_mux_wb_regs #(
    .GUARD_RST (GUARD_RST),
    .ADDR_BASE (ADDR_BASE)
  ) u_regs (
    .clk        (wb_clk_i),
    .rst        (wb_rst_i),
    .wbs_cyc_i  (wbs_cyc_i),
    .wbs_stb_i  (wbs_stb_i),
    .wbs_we_i   (wbs_we_i),
    .wbs_sel_i  (wbs_sel_i),
    .wbs_adr_i  (wbs_adr_i),
    .wbs_dat_i  (wbs_dat_i),
    .wbs_ack_o  (wbs_ack_o),
    .wbs_dat_o  (wbs_dat_o),
    .sel_i      (sel_q),
    .busy_i     (busy_q),
    .count_i    (count_q),
    .target_i   (target_q),
    .err_set_i  (err_set_c),
    .ctrl_wr_c  (ctrl_wr_c),
    .ctrl_dat_c (ctrl_dat_c),
    .guard_o    (guard_c)
  );

  // CTRL write classification: act only when idle and the target exists.
  always_comb begin
    tgt_ok_c  = ({1'b0, ctrl_dat_c} < NPROJ_LIM);
    accept_c  = ctrl_wr_c && (state_q == ST_IDLE) && tgt_ok_c;
    start_c   = accept_c && (ctrl_dat_c != sel_q);
    err_set_c = ctrl_wr_c && ((state_q != ST_IDLE) || !tgt_ok_c);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start_c) state_d = ST_DRAIN;
      ST_DRAIN:  if (cnt_q <= GUARD_W'(1)) state_d = ST_SWITCH;
      ST_SWITCH: state_d = ST_ENABLE;
      ST_ENABLE: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs, decided from the current state.
  always_comb begin
    cnt_d    = cnt_q;
    target_d = target_q;
    sel_d    = sel_q;
    en_d     = en_q;
    hold_d   = hold_q;
    irq_d    = 1'b0;
    count_d  = count_q;
    busy_d   = (state_d != ST_IDLE);
    if (accept_c) begin
      target_d = ctrl_dat_c;
    end
    if (start_c) begin
      cnt_d  = guard_c;
      en_d   = '0;
      hold_d = 1'b1;
    end
    case (state_q)
      ST_DRAIN: begin
        if (cnt_q > GUARD_W'(1)) begin
          cnt_d = cnt_q - GUARD_W'(1);
        end else begin
          sel_d = target_q;
        end
      end
      ST_SWITCH: begin
        hold_d = 1'b0;
        for (int unsigned i = 0; i < NPROJ; i++) begin
          en_d[i] = (sel_q == SEL_W'(i));
        end
        irq_d   = 1'b1;
        count_d = count_q + CNT_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cnt_q    <= '0;
      target_q <= '0;
      sel_q    <= '0;
      en_q     <= EN_RST;
      hold_q   <= 1'b0;
      busy_q   <= 1'b0;
      irq_q    <= 1'b0;
      count_q  <= '0;
    end else begin
      cnt_q    <= cnt_d;
      target_q <= target_d;
      sel_q    <= sel_d;
      en_q     <= en_d;
      hold_q   <= hold_d;
      busy_q   <= busy_d;
      irq_q    <= irq_d;
      count_q  <= count_d;
    end
  end

  assign sel_o     = sel_q;
  assign en_o      = en_q;
  assign io_hold_o = hold_q;
  assign busy_o    = busy_q;
  assign irq_o     = irq_q;

endmodule

// File: tb/tb_io_mux_ctrl.sv
// Bench for io_mux_ctrl: schedule-based reference model checked every cycle,
// directed handover scenarios with literal expectations, then random traffic.
module tb_io_mux_ctrl;

  localparam int          NP   = 3;
  localparam int          GR   = 8;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]    sel = 4'h0;
  logic [31:0]   adr = 32'h0, dat = 32'h0;
  logic          ack;
  logic [31:0]   rdat;
  logic [1:0]    sel_o;
  logic [NP-1:0] en_o;
  logic          hold, busy, irq;

  always #5 clk = ~clk;

  io_mux_ctrl #(.NPROJ(NP), .GUARD_RST(GR), .ADDR_BASE(BASE)) dut (
    .wb_clk_i (clk),  .wb_rst_i (rst),
    .wbs_cyc_i(cyc),  .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr),  .wbs_dat_i(dat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .sel_o    (sel_o), .en_o(en_o), .io_hold_o(hold), .busy_o(busy), .irq_o(irq)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a handover accepted at edge T with guard G is described
  // by d = edges since T: pads held for d in 0..G, new owner visible from d=G,
  // owner released with irq at d=G+1, idle afterwards.
  logic          m_ok = 1'b0;
  logic          m_ack, m_hold, m_busy, m_irq, m_err;
  logic [31:0]   m_dat;
  logic [1:0]    m_sel, m_trg, ho_new;
  logic [NP-1:0] m_en;
  logic [15:0]   m_count;
  logic [7:0]    m_guard;
  bit            ho_on = 1'b0;
  int            ho_t, ho_g;
  int            edge_n = 0;

  always @(posedge clk) begin : model
    logic        acc, hit;
    logic [7:0]  off;
    logic [31:0] rd;
    logic [1:0]  tgt;
    int          d;
    edge_n++;
    if (rst) begin
      m_ok = 1'b1; m_ack = 1'b0; m_dat = 32'h0; m_sel = 2'd0; m_en = NP'(1);
      m_hold = 1'b0; m_busy = 1'b0; m_irq = 1'b0; m_err = 1'b0;
      m_count = 16'h0; m_guard = 8'(GR); m_trg = 2'd0; ho_on = 1'b0;
    end else begin
      acc = cyc && stb && !m_ack;
      hit = (adr[31:8] == BASE[31:8]);
      off = adr[7:0];
      rd  = 32'h0;
      if (hit) begin
        case (off)
          8'h00:   rd = {30'd0, m_trg};
          8'h04:   rd = {m_count, 6'd0, m_err, m_busy, 6'd0, m_sel};
          8'h08:   rd = {24'd0, m_guard};
          default: rd = 32'h0;
        endcase
      end
      if (acc && hit && we && sel[0]) begin
        if (off == 8'h00) begin
          tgt = dat[1:0];
          if (m_busy || int'(tgt) >= NP) m_err = 1'b1;
          else begin
            m_trg = tgt;
            if (tgt != m_sel) begin
              ho_on = 1'b1; ho_t = edge_n; ho_g = int'(m_guard); ho_new = tgt;
            end
          end
        end else if (off == 8'h08) begin
          m_guard = (dat[7:0] == 8'h0) ? 8'd1 : dat[7:0];
        end
      end
      if (acc && hit && !we && off == 8'h04) m_err = 1'b0;
      m_dat = (acc && !we) ? rd : 32'h0;
      m_ack = acc;
      m_irq = 1'b0;
      if (ho_on) begin
        d      = edge_n - ho_t;
        m_hold = (d <= ho_g);
        m_busy = 1'b1;
        if (d >= ho_g) m_sel = ho_new;
        if (d <= ho_g) m_en = '0;
        else begin
          m_en = NP'(1) << ho_new;
          m_irq = 1'b1;
          m_count = m_count + 16'd1;
          ho_on = 1'b0;
        end
      end else begin
        m_hold = 1'b0;
        m_busy = 1'b0;
      end
    end
  end

  always @(negedge clk) begin : compare
    if (m_ok) begin
      chk("wbs_ack_o", 32'(ack),   32'(m_ack));
      chk("wbs_dat_o", rdat,       m_dat);
      chk("sel_o",     32'(sel_o), 32'(m_sel));
      chk("en_o",      32'(en_o),  32'(m_en));
      chk("io_hold_o", 32'(hold),  32'(m_hold));
      chk("busy_o",    32'(busy),  32'(m_busy));
      chk("irq_o",     32'(irq),   32'(m_irq));
    end
  end

  // Event tallies used by the directed checks.
  int            mon_cyc = 0, hold_tot = 0, irq_tot = 0, sel_at = 0, en_at = 0;
  logic [1:0]    prev_sel = 2'd0;
  logic [NP-1:0] prev_en  = '0;
  always @(negedge clk) begin : monitor
    mon_cyc++;
    if (hold === 1'b1) hold_tot++;
    if (irq === 1'b1) irq_tot++;
    if (sel_o !== prev_sel) sel_at = mon_cyc;
    if (en_o !== prev_en && en_o != '0) en_at = mon_cyc;
    prev_sel = sel_o;
    prev_en  = en_o;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wb_access(input logic [31:0] a, input logic w, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] r);
    bit got = 1'b0;
    r = 32'h0;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = s;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ack === 1'b1) begin
        got = 1'b1;
        r = rdat;
        break;
      end
    end
    if (!got) chk("ack_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wait_idle(input int lim);
    bit done = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) chk("idle_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin : stim
    logic [31:0] r, d;
    int          h0, i0, n;
    logic [3:0]  s;
    step(3);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_en", 32'(en_o), 32'h1);
    chk("rst_sel", 32'(sel_o), 32'h0);
    chk("rst_hold", 32'(hold), 32'h0);
    step(1);
    wb_access(BASE + 32'h4, 1'b0, 32'h0, 4'hF, r);
    chk("rst_status", r, 32'h0000_0000);

    // Handover 0 -> 2 with the reset guard of 8.
    h0 = hold_tot; i0 = irq_tot;
    wb_access(BASE, 1'b1, 32'h2, 4'hF, r);
    wait_idle(50);
    chk("ho_hold_cycles", 32'(hold_tot - h0), 32'd9);
    chk("ho_irq_pulses", 32'(irq_tot - i0), 32'd1);
    chk("ho_sel_before_en", 32'(en_at - sel_at), 32'd1);
    chk("ho_en", 32'(en_o), 32'h4);
    wb_access(BASE + 32'h4, 1'b0, 32'h0, 4'hF, r);
    chk("ho_status", r, 32'h0001_0002);
    wb_access(BASE, 1'b0, 32'h0, 4'hF, r);
    chk("ctrl_readback", r, 32'h2);

    // Same owner: nothing happens.
    h0 = hold_tot; i0 = irq_tot;
    wb_access(BASE, 1'b1, 32'h2, 4'hF, r);
    step(4);
    chk("same_hold", 32'(hold_tot - h0), 32'd0);
    chk("same_irq", 32'(irq_tot - i0), 32'd0);

    // Out-of-range target: sticky err, cleared by the read that reports it.
    wb_access(BASE, 1'b1, 32'h3, 4'hF, r);
    wb_access(BASE + 32'h4, 1'b0, 32'h0, 4'hF, r);
    chk("err_status", r, 32'h0001_0202);
    wb_access(BASE + 32'h4, 1'b0, 32'h0, 4'hF, r);
    chk("err_cleared", r, 32'h0001_0002);

    // Write while busy is ignored but flagged.
    wb_access(BASE, 1'b1, 32'h0, 4'hF, r);
    wb_access(BASE, 1'b1, 32'h1, 4'hF, r);
    wait_idle(50);
    chk("busy_wr_sel", 32'(sel_o), 32'h0);
    wb_access(BASE + 32'h4, 1'b0, 32'h0, 4'hF, r);
    chk("busy_wr_status", r, 32'h0002_0200);

    // GUARD=0 is stored as 1; hold then lasts two cycles.
    wb_access(BASE + 32'h8, 1'b1, 32'h0, 4'hF, r);
    wb_access(BASE + 32'h8, 1'b0, 32'h0, 4'hF, r);
    chk("guard_min", r, 32'h1);
    h0 = hold_tot;
    wb_access(BASE, 1'b1, 32'h1, 4'hF, r);
    wait_idle(50);
    chk("guard_min_hold", 32'(hold_tot - h0), 32'd2);

    // Reset during DRAIN.
    wb_access(BASE + 32'h8, 1'b1, 32'h6, 4'hF, r);
    wb_access(BASE, 1'b1, 32'h2, 4'hF, r);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_en", 32'(en_o), 32'h1);
    chk("mid_rst_sel", 32'(sel_o), 32'h0);
    chk("mid_rst_hold", 32'(hold), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_irq", 32'(irq), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    wb_access(BASE + 32'h8, 1'b0, 32'h0, 4'hF, r);
    chk("mid_rst_guard", r, 32'h8);

    // Random traffic, checked cycle by cycle against the model.
    for (int k = 0; k < 300; k++) begin
      n = int'($urandom_range(0, 99));
      s = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      if (n < 3) begin
        rst = 1'b1;
        step(1);
        rst = 1'b0;
      end else if (n < 30) begin
        d = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(0, 3));
        wb_access(BASE, 1'b1, d, s, r);
      end else if (n < 40) begin
        d = ($urandom & 32'hFFFF_FF00) | 32'($urandom_range(0, 10));
        wb_access(BASE + 32'h8, 1'b1, d, s, r);
      end else if (n < 60) begin
        wb_access(BASE + 32'h4, 1'b0, 32'h0, s, r);
      end else if (n < 68) begin
        wb_access(BASE, 1'b0, 32'h0, s, r);
      end else if (n < 76) begin
        wb_access(BASE + 32'h8, 1'b0, 32'h0, s, r);
      end else if (n < 84) begin
        case ($urandom_range(0, 2))
          0:       d = BASE + 32'h0C;
          1:       d = BASE + 32'h100;
          default: d = 32'h4000_0008;
        endcase
        wb_access(d, 1'($urandom_range(0, 1)), 32'h0000_0001, 4'hF, r);
      end else if (n < 90) begin
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h4; sel = 4'hF;
        step(int'($urandom_range(2, 6)));
        cyc = 1'b0; stb = 1'b0;
      end else begin
        wait_idle(400);
      end
      step(int'($urandom_range(0, 2)));
    end

    step(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
